// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the Harvard MIPS core to Avalon-MM bridge.
package mips_bus_pkg;

    // Bridge sequencing: one instruction fetch, an optional data access, then commit.
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXEC    = 3'd1,
        ST_DATA_RD = 3'd2,
        ST_DATA_WR = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_HALTED  = 3'd5
    } bridge_state_t;

    // The bus port is always used as a full 32-bit word port.
    localparam logic [3:0]  BYTEEN_ALL = 4'b1111;

    // Word substituted for an instruction whose fetch was aborted (sll $0,$0,0).
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    // Word-align an address: the bus never sees byte offsets.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when the low address bits carry a byte offset.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive stalled bus cycles and flags when the access must be abandoned.
// With MAX_WAIT = 0 the timer never expires, so a stalled access waits forever.
module bus_wait_timer #(
    parameter int MAX_WAIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    // One spare count so the counter can represent MAX_WAIT itself; at least one bit.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    // Abort fires on the stalled cycle where MAX_WAIT stalls have been seen in total.
    localparam logic [CW-1:0] LIMIT = CW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

    logic [CW-1:0] wait_cnt_q;

    // Stall counter: cleared on accept/abort/state change, advanced on each stalled cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wait_cnt_q <= '0;
        end else if (run) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign expired = (MAX_WAIT > 0) && run && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/mips_harvard_avalon_bridge.sv
// Bridge between a single-cycle Harvard MIPS core and one shared Avalon-MM port.
// Each instruction is fetched, its optional load/store is performed on the same bus,
// and clock_enable pulses once so the core's architectural state advances exactly
// once per instruction. Fetched word and load data are held stable for the core.
module mips_harvard_avalon_bridge
    import mips_bus_pkg::*;
#(
    parameter int MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clock_enable,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic [31:0] avl_readdata,
    input  logic        avl_waitrequest,
    output logic        err
);

    bridge_state_t state_q;
    logic [31:0]   instr_q;
    logic [31:0]   load_q;
    logic          err_q;

    logic          fetch_go;
    logic          data_rd_go;
    logic          data_wr_go;
    logic          access_active;
    logic          single_access;
    logic          stall;
    logic          timer_expired;

    // Bus strobe decode. A FETCH with the core inactive issues nothing (it halts
    // instead), and reset kills any strobe in the same cycle it is raised.
    always_comb begin
        fetch_go      = !reset && (state_q == ST_FETCH) && cpu_active;
        data_rd_go    = !reset && (state_q == ST_DATA_RD);
        data_wr_go    = !reset && (state_q == ST_DATA_WR);
        access_active = fetch_go || data_rd_go || data_wr_go;
        single_access = data_read ^ data_write;
        stall         = access_active && avl_waitrequest;
    end

    // Avalon side: address comes from the PC during fetch, otherwise from the data port.
    // Core inputs are stable within a state, so these hold while waitrequest is high.
    assign avl_read       = fetch_go || data_rd_go;
    assign avl_write      = data_wr_go;
    assign avl_address    = word_align((state_q == ST_FETCH) ? instr_address : data_address);
    assign avl_writedata  = data_writedata;
    assign avl_byteenable = BYTEEN_ALL;

    // Commit strobe: EXEC commits directly when there is no single data access to do
    // (none requested, or the illegal read+write combination); otherwise COMMIT does.
    // Held high during reset so the core's own reset logic is clocked.
    assign clock_enable = reset
                       || (state_q == ST_COMMIT)
                       || ((state_q == ST_EXEC) && !single_access);

    assign instr_readdata = instr_q;
    assign data_readdata  = load_q;
    assign err            = err_q;

    // Stall watchdog; cleared whenever the current access is not stalling or is abandoned.
    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (stall),
        .clear   (!stall || timer_expired),
        .expired (timer_expired)
    );

    // Sequencer plus the instruction/load latches and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            instr_q <= 32'h0;
            load_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!cpu_active) begin
                        state_q <= ST_HALTED;
                    end else begin
                        if (is_misaligned(instr_address[1:0])) begin
                            err_q <= 1'b1;
                        end
                        if (!avl_waitrequest) begin
                            instr_q <= avl_readdata;
                            state_q <= ST_EXEC;
                        end else if (timer_expired) begin
                            // Abandoned fetch executes as a NOP so the core still steps.
                            instr_q <= NOP_WORD;
                            err_q   <= 1'b1;
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (data_read && data_write) begin
                        err_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end else if (data_read) begin
                        state_q <= ST_DATA_RD;
                    end else if (data_write) begin
                        state_q <= ST_DATA_WR;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_DATA_RD: begin
                    if (is_misaligned(data_address[1:0])) begin
                        err_q <= 1'b1;
                    end
                    if (!avl_waitrequest) begin
                        load_q  <= avl_readdata;
                        state_q <= ST_COMMIT;
                    end else if (timer_expired) begin
                        load_q  <= 32'h0;
                        err_q   <= 1'b1;
                        state_q <= ST_COMMIT;
                    end
                end
                ST_DATA_WR: begin
                    if (is_misaligned(data_address[1:0])) begin
                        err_q <= 1'b1;
                    end
                    if (!avl_waitrequest) begin
                        state_q <= ST_COMMIT;
                    end else if (timer_expired) begin
                        err_q   <= 1'b1;
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state_q <= cpu_active ? ST_FETCH : ST_HALTED;
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_harvard_avalon_bridge.sv
// Randomised scoreboard bench for the MIPS Harvard Avalon bridge.
// Stimulus pushes expected bus transactions and expected commits; a bus responder
// and a commit monitor pop and compare independently.
module tb_mips_harvard_avalon_bridge;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_active = 1'b1;
    logic [31:0] instr_address = 32'h0;
    logic [31:0] data_address = 32'h0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = 32'h0;
    logic [31:0] avl_readdata = 32'h0;
    logic        avl_waitrequest = 1'b0;

    logic [31:0] instr_readdata;
    logic [31:0] data_readdata;
    logic        clock_enable;
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        err;

    mips_harvard_avalon_bridge #(
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_active      (cpu_active),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .clock_enable    (clock_enable),
        .avl_address     (avl_address),
        .avl_read        (avl_read),
        .avl_write       (avl_write),
        .avl_writedata   (avl_writedata),
        .avl_byteenable  (avl_byteenable),
        .avl_readdata    (avl_readdata),
        .avl_waitrequest (avl_waitrequest),
        .err             (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        bit          is_write;
        logic [31:0] wdata;
        int          waits;
    } bus_exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] ldata;
        bit          err;
        int          lat;
    } commit_exp_t;

    bus_exp_t    bus_q[$];
    commit_exp_t com_q[$];

    // Reference model state
    bit          err_m = 1'b0;
    logic [31:0] last_load = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents seen on the bus (a few fixed words, hash elsewhere).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h2110_0224;
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'hC3D2_E1F0;
    endfunction

    task automatic flush_model();
        bus_q.delete();
        com_q.delete();
        err_m     = 1'b0;
        last_load = 32'h0;
    endtask

    // Predict one instruction from the rules: cycles per phase = waits+1, or
    // MAX_WAIT if the bus stalls long enough to be abandoned.
    // kind: 0 none, 1 load, 2 store, 3 load+store (illegal)
    task automatic issue(input logic [31:0] ia, input int kind, input logic [31:0] da,
                         input logic [31:0] wd, input int wf, input int wdl);
        bus_exp_t    b;
        commit_exp_t c;
        bit          f_abort;
        bit          d_abort;
        f_abort = (wf >= MAX_WAIT);
        b.addr = ia & ~32'h3; b.is_write = 1'b0; b.wdata = 32'h0; b.waits = wf;
        bus_q.push_back(b);
        c.instr = f_abort ? 32'h0 : mem_word(ia & ~32'h3);
        c.lat   = (f_abort ? MAX_WAIT : wf + 1) + 1;
        if (ia[1:0] != 2'b00 || f_abort) err_m = 1'b1;
        if (kind == 1 || kind == 2) begin
            d_abort = (wdl >= MAX_WAIT);
            b.addr = da & ~32'h3; b.is_write = (kind == 2); b.wdata = wd; b.waits = wdl;
            bus_q.push_back(b);
            c.lat += (d_abort ? MAX_WAIT : wdl + 1) + 1;
            if (da[1:0] != 2'b00 || d_abort) err_m = 1'b1;
            if (kind == 1) last_load = d_abort ? 32'h0 : mem_word(da & ~32'h3);
        end
        c.ldata = last_load;
        c.err   = err_m;
        com_q.push_back(c);
        if (kind == 3) err_m = 1'b1;
        instr_address  = ia;
        data_address   = da;
        data_writedata = wd;
        data_read      = (kind == 1 || kind == 3);
        data_write     = (kind == 2 || kind == 3);
    endtask

    task automatic wait_commit();
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (!reset && clock_enable) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL commit_timeout: no clock_enable within %0d cycles, required a commit", n);
        end
    endtask

    task automatic run_instr(input logic [31:0] ia, input int kind, input logic [31:0] da,
                             input logic [31:0] wd, input int wf, input int wdl);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(ia, kind, da, wd, wf, wdl);
        wait_commit();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        check32("rst_clock_enable", {31'b0, clock_enable}, 32'h1);
        check32("rst_avl_read", {31'b0, avl_read}, 32'h0);
        check32("rst_avl_write", {31'b0, avl_write}, 32'h0);
        check32("rst_instr_readdata", instr_readdata, 32'h0);
        check32("rst_data_readdata", data_readdata, 32'h0);
        check32("rst_err", {31'b0, err}, 32'h0);
    endtask

    // Bus responder: pops the expected transaction at its first strobe cycle,
    // stalls for the requested number of cycles and checks the hold rule.
    bit          rsp_in_txn = 1'b0;
    int          rsp_rem = 0;
    logic [31:0] rsp_a0;
    logic [31:0] rsp_w0;
    logic        rsp_wr0;
    initial begin : responder
        bus_exp_t e;
        forever begin
            @(negedge clk);
            if (avl_read || avl_write) begin
                if (!rsp_in_txn) begin
                    rsp_in_txn = 1'b1;
                    rsp_a0  = avl_address;
                    rsp_wr0 = avl_write;
                    rsp_w0  = avl_writedata;
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL bus_unexpected: rd=%b wr=%b addr=%h, required no access",
                                 avl_read, avl_write, avl_address);
                        rsp_rem = 0;
                    end else begin
                        e = bus_q.pop_front();
                        rsp_rem = e.waits;
                        check32("bus_addr", avl_address, e.addr);
                        check32("bus_kind", {30'b0, avl_read, avl_write}, {30'b0, !e.is_write, e.is_write});
                        check32("bus_byteenable", {28'b0, avl_byteenable}, 32'hF);
                        if (e.is_write) check32("bus_wdata", avl_writedata, e.wdata);
                    end
                end else begin
                    check32("bus_hold", {avl_address[31:2], avl_read, avl_write},
                            {rsp_a0[31:2], !rsp_wr0, rsp_wr0});
                    if (rsp_wr0) check32("bus_hold_wdata", avl_writedata, rsp_w0);
                end
                avl_waitrequest = (rsp_rem > 0);
                avl_readdata    = mem_word(avl_address);
                if (rsp_rem > 0) rsp_rem--;
                else rsp_in_txn = 1'b0;
            end else begin
                rsp_in_txn      = 1'b0;
                avl_waitrequest = 1'($urandom_range(0, 1));
                avl_readdata    = $urandom;
            end
        end
    end

    // Commit monitor: every clock_enable outside reset must match the next expected commit.
    int mon_cyc = 0;
    initial begin : commit_monitor
        commit_exp_t c;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_cyc = 0;
            end else begin
                mon_cyc++;
                if (clock_enable) begin
                    if (com_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit_unexpected: clock_enable=1, required 0 (t=%0t)", $time);
                    end else begin
                        c = com_q.pop_front();
                        check32("commit_instr", instr_readdata, c.instr);
                        check32("commit_load", data_readdata, c.ldata);
                        check32("commit_err", {31'b0, err}, {31'b0, c.err});
                        check32("commit_latency", mon_cyc, c.lat);
                    end
                    mon_cyc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int kind;
        int wf;
        int wdl;
        logic [31:0] ia;
        logic [31:0] da;
        do_reset();

        // Zero-wait ALU instruction, then load with 3 data stalls, then store.
        run_instr(32'h100, 0, 32'h0, 32'h0, 0, 0);
        run_instr(32'h104, 1, 32'h1000, 32'h0, 0, 3);
        run_instr(32'h108, 2, 32'h2004, 32'h1234_5678, 0, 0);
        // Fetch stuck in waitrequest -> NOP, then a stuck load -> 0.
        run_instr(32'h10C, 0, 32'h0, 32'h0, 100, 0);
        run_instr(32'h110, 1, 32'h3000, 32'h0, 0, 50);

        // Reset during a stalled data read.
        do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(32'h300, 1, 32'h1500, 32'h0, 0, 3);
        repeat (3) @(posedge clk);
        #1;
        check32("pre_reset_avl_read", {31'b0, avl_read}, 32'h1);
        reset = 1'b1;
        flush_model();
        @(negedge clk);
        check32("mid_reset_avl_read", {31'b0, avl_read}, 32'h0);
        check32("mid_reset_clock_enable", {31'b0, clock_enable}, 32'h1);
        run_instr(32'h400, 0, 32'h0, 32'h0, 1, 0);

        // Randomised traffic, reset every 30 instructions to clear the sticky error.
        for (int i = 0; i < 150; i++) begin
            if (i % 30 == 0) do_reset();
            kind = int'($urandom_range(0, 19));
            kind = (kind < 8) ? 0 : (kind < 13) ? 1 : (kind < 19) ? 2 : 3;
            wf  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            wdl = ($urandom_range(0, 14) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            ia = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            da = {18'b0, 12'($urandom_range(0, 4095)), 2'b00};
            if ($urandom_range(0, 19) == 0) ia[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) da[1:0] = 2'($urandom_range(1, 3));
            run_instr(ia, kind, da, $urandom, wf, wdl);
        end

        // Misaligned load, then halt at its commit.
        do_reset();
        run_instr(32'h500, 1, 32'h1002, 32'h0, 0, 0);
        cpu_active = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check32("halted_idle", {29'b0, avl_read, avl_write, clock_enable}, 32'h0);
        end
        check32("halted_err", {31'b0, err}, 32'h1);
        check32("bus_queue_empty", bus_q.size(), 32'h0);
        check32("commit_queue_empty", com_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
